// File: rtl/vram_arbiter_if.sv
// Bus bundle between the CPU, the text fetch, the character RAM
// and the arbiter that shares that RAM.
interface vram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              vid_drop;
  logic [7:0]        drop_cnt;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_wdata, vid_req, vid_addr,
    output ram_rdata,
    input  cpu_rdata, cpu_ack, vid_data,
    input  vid_valid, vid_drop, drop_cnt,
    input  ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_wdata, vid_req, vid_addr,
    input  ram_rdata,
    output cpu_rdata, cpu_ack, vid_data,
    output vid_valid, vid_drop, drop_cnt,
    output ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Character RAM arbiter: video fetch first, CPU bounded by a
// starvation counter, one-entry pending buffer for displaced fetches.
module vram_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           resetn,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    C_IDLE, C_WAIT, C_ISSUED, C_ACK
  } cpu_st_t;

  typedef enum logic [1:0] {
    G_NONE, G_CPU, G_PEND, G_VID
  } gnt_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  cpu_st_t           cst;
  gnt_t              gnt;
  logic [3:0]        starve;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;
  logic              t1_cpu, t1_vid, t1_rd;
  logic              t2_cpu, t2_vid, t2_rd;
  logic              cpu_open, ovr;
  logic              vid_park, drop;
  logic [DATA_W-1:0] rdata;

  assign rdata = bus.ram_rdata;

  always_comb begin
    cpu_open = bus.cpu_req &&
               (cst == C_IDLE || cst == C_WAIT);
    ovr      = (cst == C_WAIT) && (starve == LIMIT);
    gnt      = G_NONE;
    priority case (1'b1)
      ovr:         gnt = G_CPU;
      pend_v:      gnt = G_PEND;
      bus.vid_req: gnt = G_VID;
      cpu_open:    gnt = G_CPU;
      default:     gnt = G_NONE;
    endcase
    vid_park = bus.vid_req && (gnt != G_VID);
    // an unserviced older entry loses its slot to the new fetch
    drop     = vid_park && pend_v && (gnt != G_PEND);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cst           <= C_IDLE;
      starve        <= '0;
      pend_v        <= 1'b0;
      pend_addr     <= '0;
      t1_cpu        <= 1'b0;
      t1_vid        <= 1'b0;
      t1_rd         <= 1'b0;
      t2_cpu        <= 1'b0;
      t2_vid        <= 1'b0;
      t2_rd         <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.vid_data  <= '0;
      bus.vid_valid <= 1'b0;
      bus.vid_drop  <= 1'b0;
      bus.drop_cnt  <= '0;
    end else begin
      bus.ram_we    <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.vid_valid <= 1'b0;
      bus.vid_drop  <= drop;
      if (drop && bus.drop_cnt != 8'hFF)
        bus.drop_cnt <= bus.drop_cnt + 8'd1;

      unique case (gnt)
        G_CPU: begin
          bus.ram_addr  <= bus.cpu_addr;
          bus.ram_we    <= bus.cpu_we;
          bus.ram_wdata <= bus.cpu_wdata;
        end
        G_PEND: bus.ram_addr <= pend_addr;
        G_VID:  bus.ram_addr <= bus.vid_addr;
        default: ;
      endcase

      t1_cpu <= (gnt == G_CPU);
      t1_vid <= (gnt == G_PEND) || (gnt == G_VID);
      t1_rd  <= !bus.cpu_we;
      t2_cpu <= t1_cpu;
      t2_vid <= t1_vid;
      t2_rd  <= t1_rd;

      if (t2_cpu) begin
        bus.cpu_ack <= 1'b1;
        if (t2_rd)
          bus.cpu_rdata <= rdata;
      end
      if (t2_vid) begin
        bus.vid_valid <= 1'b1;
        bus.vid_data  <= rdata;
      end

      if (vid_park) begin
        pend_v    <= 1'b1;
        pend_addr <= bus.vid_addr;
      end else if (gnt == G_PEND) begin
        pend_v    <= 1'b0;
      end

      if (gnt == G_CPU)
        starve <= '0;
      else if (cst == C_WAIT && starve != LIMIT)
        starve <= starve + 4'd1;

      // ISSUED waits for the RAM data to come back
      unique case (cst)
        C_IDLE:
          if (gnt == G_CPU)     cst <= C_ISSUED;
          else if (bus.cpu_req) cst <= C_WAIT;
        C_WAIT:
          if (gnt == G_CPU)     cst <= C_ISSUED;
        C_ISSUED:
          if (t2_cpu)           cst <= C_ACK;
        C_ACK:                  cst <= C_IDLE;
        default:                cst <= C_IDLE;
      endcase
    end
  end
endmodule
